inst_sram_responder: RTL

//  Memory-side responder for the instruction SRAM port driven by the IF stage.
//  - Answers inst_sram_en/addr with registered read data one cycle later.
//  - Supports byte-lane writes.
//  - Has a handshaked loader that fills the array from a word stream before the core runs.
//  - Sits between the CPU top and the instruction memory array; replaces an external SRAM model.

---
 rtl/inst_sram_responder_if.sv | 29 ++
 rtl/inst_sram_responder.sv | 92 +++++++++
 2 files changed

// File: rtl/inst_sram_responder_if.sv
// inst_sram_responder_if: IF-stage instruction SRAM port plus array loader handshake
//   CPU side : inst_sram_en/we/addr/wdata -> responder, inst_sram_rdata <- responder
//   Loader   : load_start/valid/last/data -> responder, load_ready/load_done <- responder
//   Status   : busy, acc_err <- responder
interface inst_sram_responder_if;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        load_start;
    logic        load_valid;
    logic        load_last;
    logic [31:0] load_data;
    logic        load_ready;
    logic        load_done;
    logic        busy;
    logic        acc_err;
    modport master (
        output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
        output load_start, load_valid, load_last, load_data,
        input  inst_sram_rdata, load_ready, load_done, busy, acc_err
    );
    modport slave (
        input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
        input  load_start, load_valid, load_last, load_data,
        output inst_sram_rdata, load_ready, load_done, busy, acc_err
    );
endinterface

// File: rtl/inst_sram_responder.sv
// inst_sram_responder: instruction memory with 1-cycle registered reads, byte-lane writes and a word-stream loader
//   clk   : clock, all state on posedge
//   reset : asynchronous active-high reset (array contents are kept)
//   bus   : slave side of inst_sram_responder_if (CPU port, loader handshake, busy/acc_err status)
module inst_sram_responder #(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h1c000000,
    parameter logic [31:0] NOP_INST  = 32'h03400000
) (
    input logic                  clk,
    input logic                  reset,
    inst_sram_responder_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;
    state_e            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [31:0]       rdata_q, rdata_d;
    logic              acc_err_q, acc_err_d;
    logic              busy_q, ready_q, done_q;
    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       off;
    logic [ADDR_W-1:0] idx;
    logic              ok, cpu_act, cpu_we, ld_we, ld_end;
    // Offset wraps, so addresses below BASE_ADDR land far above the array and fail the range test
    assign off     = bus.inst_sram_addr - BASE_ADDR;
    assign idx     = off[ADDR_W+1:2];
    assign ok      = (off < 32'(4 * DEPTH)) && (bus.inst_sram_addr[1:0] == 2'b00);
    // The CPU port is only live while the loader is idle; DONE still blocks it
    assign cpu_act = bus.inst_sram_en && (state_q == IDLE);
    assign cpu_we  = cpu_act && ok && (|bus.inst_sram_we);
    assign ld_we   = (state_q == LOAD) && bus.load_valid;
    assign ld_end  = ld_we && (bus.load_last || (&ptr_q));
    always_comb begin
        rdata_d   = !bus.inst_sram_en ? rdata_q : (cpu_act && ok) ? mem_q[idx] : NOP_INST;
        acc_err_d = acc_err_q | (cpu_act & ~ok);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q   <= NOP_INST;
            acc_err_q <= 1'b0;
        end else begin
            rdata_q   <= rdata_d;
            acc_err_q <= acc_err_d;
        end
    end
    // Array has no reset; loader and CPU writes are exclusive since the CPU is blocked outside IDLE
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem_q[ptr_q] <= bus.load_data;
        end else if (cpu_we) begin
            for (int i = 0; i < 4; i++)
                if (bus.inst_sram_we[i]) mem_q[idx][8*i +: 8] <= bus.inst_sram_wdata[8*i +: 8];
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (bus.load_start) begin
                    state_q <= LOAD;
                    ptr_q   <= '0;
                    busy_q  <= 1'b1;
                    ready_q <= 1'b1;
                end
                LOAD: if (ld_end) begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                    done_q  <= 1'b1;
                end else if (ld_we) begin
                    ptr_q <= ptr_q + 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.inst_sram_rdata = rdata_q;
    assign bus.acc_err         = acc_err_q;
    assign bus.busy            = busy_q;
    assign bus.load_ready      = ready_q;
    assign bus.load_done       = done_q;
endmodule
